// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement adder/subtracter whose carry chain is cut
// into STAGES equal slices, one slice per pipeline stage, with a valid/ready
// handshake on both sides and ARM-style NZCV flags.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; a, b, sub are taken when both are high
//   a, b, sub           operands; sub=1 computes a + ~b + 1
//   out_valid/out_ready output handshake; result and flags held while stalled
//   result              a +/- b modulo 2^WIDTH
//   negative, zero      result[WIDTH-1], result == 0
//   carry_out           carry out of the MSB (1 = no borrow for sub)
//   overflow            signed overflow
//
// An operation presented in cycle t with out_ready high appears on the
// outputs in cycle t+STAGES.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned S    = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  // Per-stage state: operands (b already conditionally inverted), partial
  // result, slice carry and running zero flag.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic [STAGES-1:0] adv_c;
  logic [STAGES-1:0] load_c;
  logic              accept_c;

  // Occupancy: walk from the output back so empty stages absorb bubbles.
  always_comb begin
    adv_c  = '0;
    load_c = '0;
    for (int i = int'(LAST); i >= 0; i--) begin
      if (i == int'(LAST)) adv_c[i] = valid_q[i] & out_ready;
      else                 adv_c[i] = valid_q[i] & load_c[i+1];
      load_c[i] = ~valid_q[i] | adv_c[i];
    end
  end

  assign in_ready = ~reset & load_c[0];
  assign accept_c = in_valid & in_ready;

  // Slice k of the add is done while the operation moves into stage k.
  always_comb begin
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_res;
    logic             src_cy;
    logic             src_zero;
    logic             take;
    logic [S:0]       slice;

    valid_d  = valid_q;
    cy_d     = cy_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    src_a    = '0;
    src_b    = '0;
    src_res  = '0;
    src_cy   = 1'b0;
    src_zero = 1'b0;
    take     = 1'b0;
    slice    = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      res_d[k] = res_q[k];
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_a    = a;
        src_b    = sub ? ~b : b;
        src_res  = '0;
        src_cy   = sub;
        src_zero = 1'b1;
        take     = accept_c;
      end else begin
        src_a    = opa_q[k-1];
        src_b    = opb_q[k-1];
        src_res  = res_q[k-1];
        src_cy   = cy_q[k-1];
        src_zero = zero_q[k-1];
        take     = adv_c[k-1];
      end

      slice = {1'b0, src_a[k*S +: S]} + {1'b0, src_b[k*S +: S]} + (S+1)'(src_cy);

      if (load_c[k]) valid_d[k] = take;

      if (take) begin
        opa_d[k]            = src_a;
        opb_d[k]            = src_b;
        res_d[k]            = src_res;
        res_d[k][k*S +: S]  = slice[S-1:0];
        cy_d[k]             = slice[S];
        zero_d[k]           = src_zero & (slice[S-1:0] == '0);
        // Carry into the MSB is a^b^sum at that bit; V = carry-in ^ carry-out.
        if (k == LAST) ovf_d = slice[S] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ slice[S-1];
      end
    end
  end

  // Stage registers; reset drops every in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cy_q    <= '0;
      zero_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cy_q    <= cy_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign result    = res_q[LAST];
  assign negative  = res_q[LAST][WIDTH-1];
  assign zero      = zero_q[LAST];
  assign carry_out = cy_q[LAST];
  assign overflow  = ovf_q;

endmodule
